// File: rtl/uio_arbiter.sv
// Round-robin burst arbiter sharing the uio pad bank between two internal requesters.
// Define UIO_ARB_TURNAROUND_EN to insert a forced-idle turnaround gap between owners.
module uio_arbiter #(
   parameter int unsigned MAX_BURST   = 4,
   parameter int unsigned TURN_CYCLES = 1,
   parameter logic [7:0]  OE_MASK     = 8'hFF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       req0,
   input  logic       req1,
   input  logic       wr0,
   input  logic       wr1,
   input  logic [7:0] wdata0,
   input  logic [7:0] wdata1,
   output logic       gnt0,
   output logic       gnt1,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   output logic [7:0] rdata,
   output logic       rvalid,
   output logic       rsrc
);

   localparam logic [3:0] MAX_BURST_L = 4'(MAX_BURST);

`ifdef UIO_ARB_TURNAROUND_EN
   localparam logic [1:0] TURN_CYCLES_L = 2'(TURN_CYCLES);
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_OWN = 2'd1, ST_TURN = 2'd2} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_OWN = 2'd1} state_t;
   logic [1:0] turn_cycles_unused_s;
   assign turn_cycles_unused_s = 2'(TURN_CYCLES);
`endif

   // On a tie the requester that did not own the bus last wins.
   function automatic logic pick_winner(input logic r0, input logic r1, input logic last);
      logic win;
      if (r0 && r1) begin
         win = ~last;
      end else if (r1) begin
         win = 1'b1;
      end else begin
         win = 1'b0;
      end
      return win;
   endfunction

   state_t     state_q, state_d;
   logic       owner_q, owner_d;
   logic       dir_q, dir_d;
   logic       last_q, last_d;
   logic [3:0] beat_q, beat_d;
`ifdef UIO_ARB_TURNAROUND_EN
   logic [1:0] turn_q, turn_d;
`endif
   logic       gnt0_q, gnt0_d;
   logic       gnt1_q, gnt1_d;
   logic [7:0] uio_out_q, uio_out_d;
   logic [7:0] uio_oe_q, uio_oe_d;
   logic [7:0] rdata_q, rdata_d;
   logic       rvalid_q, rvalid_d;
   logic       rsrc_q, rsrc_d;

   logic       req_own_s;
   logic [7:0] wdata_own_s;
   logic       any_req_s;
   logic       win_s;
   logic       beat_s;
   logic       last_beat_s;
   logic       arb_s;
   logic       exit_s;

   assign req_own_s   = owner_q ? req1 : req0;
   assign wdata_own_s = owner_q ? wdata1 : wdata0;
   assign any_req_s   = req0 | req1;
   assign win_s       = pick_winner(req0, req1, last_q);
   assign beat_s      = (state_q == ST_OWN) && req_own_s;
   assign last_beat_s = beat_s && ((beat_q + 4'd1) == MAX_BURST_L);

   // Next-state and output-register computation for the arbiter FSM.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      dir_d     = dir_q;
      last_d    = last_q;
      beat_d    = beat_q;
`ifdef UIO_ARB_TURNAROUND_EN
      turn_d    = turn_q;
`endif
      gnt0_d    = gnt0_q;
      gnt1_d    = gnt1_q;
      uio_out_d = uio_out_q;
      uio_oe_d  = 8'h00;
      rdata_d   = rdata_q;
      rvalid_d  = 1'b0;
      rsrc_d    = rsrc_q;
      arb_s     = 1'b0;
      exit_s    = 1'b0;

      if (!ena) begin
         state_d = ST_IDLE;
         gnt0_d  = 1'b0;
         gnt1_d  = 1'b0;
         beat_d  = 4'd0;
`ifdef UIO_ARB_TURNAROUND_EN
         turn_d  = 2'd0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               arb_s = any_req_s;
            end
            ST_OWN: begin
               if (beat_s) begin
                  if (dir_q) begin
                     uio_out_d = wdata_own_s;
                     uio_oe_d  = OE_MASK;
                  end else begin
                     rdata_d  = uio_in;
                     rsrc_d   = owner_q;
                     rvalid_d = 1'b1;
                  end
                  exit_s = last_beat_s;
                  beat_d = beat_q + 4'd1;
               end else begin
                  exit_s = 1'b1;
               end
               if (exit_s) begin
                  gnt0_d = 1'b0;
                  gnt1_d = 1'b0;
                  beat_d = 4'd0;
`ifdef UIO_ARB_TURNAROUND_EN
                  // A trailing write drive takes one extra cycle before the counted gap.
                  state_d = ST_TURN;
                  turn_d  = (beat_s && dir_q) ? 2'd0 : 2'd1;
`else
                  state_d = ST_IDLE;
                  arb_s   = any_req_s;
`endif
               end else begin
                  state_d = ST_OWN;
               end
            end
`ifdef UIO_ARB_TURNAROUND_EN
            ST_TURN: begin
               if (turn_q >= TURN_CYCLES_L) begin
                  state_d = ST_IDLE;
                  turn_d  = 2'd0;
                  arb_s   = any_req_s;
               end else begin
                  turn_d = turn_q + 2'd1;
               end
            end
`endif
            default: begin
               state_d = ST_IDLE;
               gnt0_d  = 1'b0;
               gnt1_d  = 1'b0;
               beat_d  = 4'd0;
            end
         endcase

         if (arb_s) begin
            state_d = ST_OWN;
            owner_d = win_s;
            dir_d   = win_s ? wr1 : wr0;
            last_d  = win_s;
            beat_d  = 4'd0;
            gnt0_d  = ~win_s;
            gnt1_d  = win_s;
         end else begin
            owner_d = owner_d;
         end
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         owner_q   <= 1'b0;
         dir_q     <= 1'b0;
         last_q    <= 1'b1;
         beat_q    <= 4'd0;
`ifdef UIO_ARB_TURNAROUND_EN
         turn_q    <= 2'd0;
`endif
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         uio_out_q <= 8'h00;
         uio_oe_q  <= 8'h00;
         rdata_q   <= 8'h00;
         rvalid_q  <= 1'b0;
         rsrc_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         dir_q     <= dir_d;
         last_q    <= last_d;
         beat_q    <= beat_d;
`ifdef UIO_ARB_TURNAROUND_EN
         turn_q    <= turn_d;
`endif
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         uio_out_q <= uio_out_d;
         uio_oe_q  <= uio_oe_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
         rsrc_q    <= rsrc_d;
      end
   end

   assign gnt0    = gnt0_q;
   assign gnt1    = gnt1_q;
   assign uio_out = uio_out_q;
   assign uio_oe  = uio_oe_q;
   assign rdata   = rdata_q;
   assign rvalid  = rvalid_q;
   assign rsrc    = rsrc_q;

endmodule

// File: tb/tb_uio_arbiter.sv
// Scoreboard bench for uio_arbiter: the driver queues per-cycle expectations, a negedge monitor checks them.
module tb_uio_arbiter;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic       req0, req1;
   logic       wr0, wr1;
   logic [7:0] wdata0, wdata1;
   logic       gnt0, gnt1;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;
   logic [7:0] rdata;
   logic       rvalid;
   logic       rsrc;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   typedef struct {
      int         cyc;
      int         tid;
      logic       g0;
      logic       g1;
      logic [7:0] oe;
      logic [7:0] out;
      logic       rv;
      logic [7:0] rd;
      logic       rs;
   } exp_t;

   exp_t exp_q[$];

   uio_arbiter #(.MAX_BURST(4), .TURN_CYCLES(1), .OE_MASK(8'hFF)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1),
      .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe),
      .rdata(rdata), .rvalid(rvalid), .rsrc(rsrc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic string tname(input int tid);
      case (tid)
         1: return "reset_tie";
         2: return "write_burst";
         3: return "read_beat";
         4: return "ena_abort";
         5: return "contention";
         default: return "unknown";
      endcase
   endfunction

   task automatic exp_at(input int tid, input int c, input logic g0, input logic g1,
                         input logic [7:0] oe, input logic [7:0] out, input logic rv,
                         input logic [7:0] rd, input logic rs);
      exp_t e;
      e.cyc = c; e.tid = tid; e.g0 = g0; e.g1 = g1; e.oe = oe; e.out = out;
      e.rv = rv; e.rd = rd; e.rs = rs;
      exp_q.push_back(e);
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; ena = 1'b1; req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
      wdata0 = 8'h00; wdata1 = 8'h00; uio_in = 8'h00;
      wait_neg(2);
      rst_n = 1'b1;
   endtask

   // Monitor: compare the DUT against the queued expectation for this cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL %s cyc%0d: expectation was never sampled (now cyc%0d)", tname(e.tid), e.cyc, cyc);
         end
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (gnt0 !== e.g0 || gnt1 !== e.g1 || uio_oe !== e.oe || uio_out !== e.out ||
                rvalid !== e.rv || rdata !== e.rd || rsrc !== e.rs) begin
               n_fail++;
               $display("FAIL %s cyc%0d: got g0=%b g1=%b oe=%h out=%h rv=%b rd=%h rs=%b, want g0=%b g1=%b oe=%h out=%h rv=%b rd=%h rs=%b",
                        tname(e.tid), cyc, gnt0, gnt1, uio_oe, uio_out, rvalid, rdata, rsrc,
                        e.g0, e.g1, e.oe, e.out, e.rv, e.rd, e.rs);
            end
         end
      end
   end

   // Driver: directed scenarios with hand-computed per-cycle expectations.
   initial begin
      int b;
      rst_n = 1'b0; ena = 1'b1; req0 = 1'b1; req1 = 1'b1; wr0 = 1'b1; wr1 = 1'b1;
      wdata0 = 8'h00; wdata1 = 8'h00; uio_in = 8'h00;

      // Reset with both requests high, then the tie goes to requester 0.
      exp_at(1, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
      exp_at(1, 2, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
      exp_at(1, 3, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0);
      exp_at(1, 4, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
      exp_at(1, 5, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
      wait_neg(2);
      rst_n = 1'b1;
      wait_neg(1);
      req0 = 1'b0; req1 = 1'b0;
      wait_neg(3);

      // Single write burst of three beats, then the request drops.
      do_reset();
      b = cyc;
      exp_at(2, b+1, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0);
      exp_at(2, b+2, 1, 0, 8'hFF, 8'h11, 0, 8'h00, 0);
      exp_at(2, b+3, 1, 0, 8'hFF, 8'h22, 0, 8'h00, 0);
      exp_at(2, b+4, 1, 0, 8'hFF, 8'h33, 0, 8'h00, 0);
      exp_at(2, b+5, 0, 0, 8'h00, 8'h33, 0, 8'h00, 0);
      exp_at(2, b+6, 0, 0, 8'h00, 8'h33, 0, 8'h00, 0);
      req0 = 1'b1; wr0 = 1'b1; wdata0 = 8'h11;
      wait_neg(2); wdata0 = 8'h22;
      wait_neg(1); wdata0 = 8'h33;
      wait_neg(1); req0 = 1'b0;
      wait_neg(2);

      // Read beat by requester 1; a wr1 flip mid-burst must be ignored.
      do_reset();
      b = cyc;
      exp_at(3, b+1, 0, 1, 8'h00, 8'h00, 0, 8'h00, 0);
      exp_at(3, b+2, 0, 1, 8'h00, 8'h00, 1, 8'hA5, 1);
      exp_at(3, b+3, 0, 0, 8'h00, 8'h00, 0, 8'hA5, 1);
      exp_at(3, b+4, 0, 0, 8'h00, 8'h00, 0, 8'hA5, 1);
      req1 = 1'b1; wr1 = 1'b0; uio_in = 8'hA5;
      wait_neg(1); wr1 = 1'b1;
      wait_neg(1); req1 = 1'b0; uio_in = 8'h5A;
      wait_neg(2);

      // ena drops during the second write beat; re-arbitration honours last owner.
      do_reset();
      b = cyc;
      exp_at(4, b+1, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0);
      exp_at(4, b+2, 1, 0, 8'hFF, 8'h44, 0, 8'h00, 0);
      exp_at(4, b+3, 0, 0, 8'h00, 8'h44, 0, 8'h00, 0);
      exp_at(4, b+4, 0, 0, 8'h00, 8'h44, 0, 8'h00, 0);
      exp_at(4, b+5, 0, 1, 8'h00, 8'h44, 0, 8'h00, 0);
      exp_at(4, b+6, 0, 1, 8'hFF, 8'h99, 0, 8'h00, 0);
      exp_at(4, b+7, 0, 0, 8'h00, 8'h99, 0, 8'h00, 0);
      req0 = 1'b1; req1 = 1'b1; wr0 = 1'b1; wr1 = 1'b1; wdata0 = 8'h44; wdata1 = 8'h99;
      wait_neg(2); wdata0 = 8'h55; ena = 1'b0;
      wait_neg(2); ena = 1'b1;
      wait_neg(2); req0 = 1'b0; req1 = 1'b0;
      wait_neg(2);

      // Contention: full bursts alternate between the two requesters.
      do_reset();
      b = cyc;
      exp_at(5, b+1, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0);
      exp_at(5, b+2, 1, 0, 8'hFF, 8'hA0, 0, 8'h00, 0);
      exp_at(5, b+3, 1, 0, 8'hFF, 8'hA0, 0, 8'h00, 0);
      exp_at(5, b+4, 1, 0, 8'hFF, 8'hA0, 0, 8'h00, 0);
`ifdef UIO_ARB_TURNAROUND_EN
      exp_at(5, b+5,  0, 0, 8'hFF, 8'hA0, 0, 8'h00, 0);
      exp_at(5, b+6,  0, 0, 8'h00, 8'hA0, 0, 8'h00, 0);
      exp_at(5, b+7,  0, 1, 8'h00, 8'hA0, 0, 8'h00, 0);
      exp_at(5, b+8,  0, 1, 8'hFF, 8'hB1, 0, 8'h00, 0);
      exp_at(5, b+9,  0, 1, 8'hFF, 8'hB1, 0, 8'h00, 0);
      exp_at(5, b+10, 0, 1, 8'hFF, 8'hB1, 0, 8'h00, 0);
      exp_at(5, b+11, 0, 0, 8'hFF, 8'hB1, 0, 8'h00, 0);
      exp_at(5, b+12, 0, 0, 8'h00, 8'hB1, 0, 8'h00, 0);
      exp_at(5, b+13, 1, 0, 8'h00, 8'hB1, 0, 8'h00, 0);
      exp_at(5, b+14, 1, 0, 8'hFF, 8'hA0, 0, 8'h00, 0);
`else
      exp_at(5, b+5,  0, 1, 8'hFF, 8'hA0, 0, 8'h00, 0);
      exp_at(5, b+6,  0, 1, 8'hFF, 8'hB1, 0, 8'h00, 0);
      exp_at(5, b+7,  0, 1, 8'hFF, 8'hB1, 0, 8'h00, 0);
      exp_at(5, b+8,  0, 1, 8'hFF, 8'hB1, 0, 8'h00, 0);
      exp_at(5, b+9,  1, 0, 8'hFF, 8'hB1, 0, 8'h00, 0);
      exp_at(5, b+10, 1, 0, 8'hFF, 8'hA0, 0, 8'h00, 0);
      exp_at(5, b+11, 1, 0, 8'hFF, 8'hA0, 0, 8'h00, 0);
`endif
      req0 = 1'b1; req1 = 1'b1; wr0 = 1'b1; wr1 = 1'b1; wdata0 = 8'hA0; wdata1 = 8'hB1;
      wait_neg(14);
      req0 = 1'b0; req1 = 1'b0;
      wait_neg(4);

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
